// File: rtl/aes_ctrl_pkg.sv
// Shared AES control definitions: sequencer state encoding, round constants
// and the GF(2^8) xtime helper also used by the MixColumns datapath.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    ROUND = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] RCON_POLY  = 8'h1B;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: after key_start it issues the AddRoundKey load, ten
// round strobes with matching Rcon steps, then a one-cycle transformer_done.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       key_start,
  output logic       busy,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic       dp_final,
  output logic       ke_step,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       transformer_done,
  output logic       cipher_valid,
  output state_t     fsm_state
);

  // Handshake: there is no back-pressure. key_start is a level that is acted
  // on only in IDLE while armed; every strobe is valid for exactly one cycle
  // and the datapath/expander must accept it (they honour ROUND_LAT).

  localparam logic [3:0] CNT_LAST = 4'(ROUND_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] round_q, round_nxt;
  logic [7:0] rcon_q, rcon_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       armed, armed_nxt;
  logic       valid_q, valid_nxt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      cnt     <= 4'd0;
      armed   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
      rcon_q  <= rcon_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    round_nxt        = round_q;
    rcon_nxt         = rcon_q;
    cnt_nxt          = cnt;
    valid_nxt        = valid_q;
    dp_load          = 1'b0;
    dp_round_en      = 1'b0;
    transformer_done = 1'b0;

    // A start still held after DONE must be released once before it counts again.
    armed_nxt = armed;
    if (state == DONE) armed_nxt = 1'b0;
    if (!key_start)    armed_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (key_start && armed) begin
          state_nxt = LOAD;
          valid_nxt = 1'b0;
        end
      end
      LOAD: begin
        dp_load   = 1'b1;
        state_nxt = ROUND;
        round_nxt = 4'd1;
        rcon_nxt  = RCON_INIT;
        cnt_nxt   = 4'd0;
      end
      ROUND: begin
        dp_round_en = (cnt == 4'd0);
        if (cnt == CNT_LAST) begin
          cnt_nxt = 4'd0;
          if (round_q == NUM_ROUNDS) begin
            state_nxt = DONE;
            valid_nxt = 1'b1;
          end else begin
            round_nxt = round_q + 4'd1;
            rcon_nxt  = xtime(rcon_q);
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        transformer_done = 1'b1;
        state_nxt        = IDLE;
        round_nxt        = 4'd0;
        rcon_nxt         = RCON_INIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ke_step      = dp_round_en;
  assign dp_final     = (state == ROUND) && (round_q == NUM_ROUNDS);
  assign busy         = (state == LOAD) || (state == ROUND);
  assign round        = round_q;
  assign rcon         = rcon_q;
  assign cipher_valid = valid_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: one instance at ROUND_LAT=1 driven
// from a vector table, one at ROUND_LAT=3 for latency, early-drop and reset cases.
module tb_aes_round_sequencer;
  import aes_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n, ks1, ks3;

  logic       busy1, load1, ren1, final1, ke1, done1, cv1;
  logic [3:0] round1;
  logic [7:0] rcon1;
  state_t     st1;
  logic       busy3, load3, ren3, final3, ke3, done3, cv3;
  logic [3:0] round3;
  logic [7:0] rcon3;
  state_t     st3;

  aes_round_sequencer #(.ROUND_LAT(1)) dut1 (
    .clk(clk), .rst_(rst1_n), .key_start(ks1),
    .busy(busy1), .dp_load(load1), .dp_round_en(ren1), .dp_final(final1),
    .ke_step(ke1), .round(round1), .rcon(rcon1),
    .transformer_done(done1), .cipher_valid(cv1), .fsm_state(st1)
  );

  aes_round_sequencer #(.ROUND_LAT(3)) dut3 (
    .clk(clk), .rst_(rst3_n), .key_start(ks3),
    .busy(busy3), .dp_load(load3), .dp_round_en(ren3), .dp_final(final3),
    .ke_step(ke3), .round(round3), .rcon(rcon3),
    .transformer_done(done3), .cipher_valid(cv3), .fsm_state(st3)
  );

  // observation word: {busy, load, round_en, ke_step, final, round, rcon, done, valid}
  typedef struct {
    logic        ks;
    logic [18:0] exp;
  } vec_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  rcon_tab [0:10];
  vec_t        vecs [0:13];

  function automatic logic [18:0] mk(input logic b, input logic l, input logic r,
                                     input logic f, input logic [3:0] rd,
                                     input logic [7:0] rc, input logic d,
                                     input logic v);
    return {b, l, r, r, f, rd, rc, d, v};
  endfunction

  function automatic logic [18:0] obs(input int sel);
    if (sel == 1) return {busy1, load1, ren1, ke1, final1, round1, rcon1, done1, cv1};
    return {busy3, load3, ren3, ke3, final3, round3, rcon3, done3, cv3};
  endfunction

  // Expected outputs k cycles after key_start is first driven in IDLE.
  function automatic logic [18:0] model(input int lat, input int k, input logic prev_cv);
    int last;
    int r;
    last = 1 + 10 * lat;
    if (k == 0) return mk(0, 0, 0, 0, 4'd0, 8'h01, 0, prev_cv);
    if (k == 1) return mk(1, 1, 0, 0, 4'd0, 8'h01, 0, 0);
    if (k <= last) begin
      r = (k - 2) / lat + 1;
      return mk(1, 0, ((k - 2) % lat) == 0, r == 10, 4'(r), rcon_tab[r], 0, 0);
    end
    if (k == last + 1) return mk(0, 0, 0, 0, 4'd10, 8'h36, 1, 1);
    return mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 1);
  endfunction

  // scoreboard compare
  task automatic check(input string name, input int k, input logic [18:0] act,
                       input logic [18:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %05h expected %05h", name, k, act, exp);
    end
  endtask

  task automatic drive_ks(input int sel, input logic v);
    if (sel == 1) ks1 = v;
    else ks3 = v;
  endtask

  // driver: key_start held until drop_at, one compare per cycle on the negedge
  task automatic run_model(input int sel, input int lat, input logic prev_cv,
                           input int drop_at, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      drive_ks(sel, k < drop_at);
      @(negedge clk);
      check(name, k, obs(sel), model(lat, k, prev_cv));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rcon_tab[0]  = 8'h01;
    rcon_tab[1]  = 8'h01; rcon_tab[2]  = 8'h02; rcon_tab[3]  = 8'h04;
    rcon_tab[4]  = 8'h08; rcon_tab[5]  = 8'h10; rcon_tab[6]  = 8'h20;
    rcon_tab[7]  = 8'h40; rcon_tab[8]  = 8'h80; rcon_tab[9]  = 8'h1B;
    rcon_tab[10] = 8'h36;

    vecs[0]  = '{1'b1, mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 0)};
    vecs[1]  = '{1'b1, mk(1, 1, 0, 0, 4'd0, 8'h01, 0, 0)};
    for (int k = 2; k <= 11; k++)
      vecs[k] = '{1'b1, mk(1, 0, 1, k == 11, 4'(k - 1), rcon_tab[k - 1], 0, 0)};
    vecs[12] = '{1'b1, mk(0, 0, 0, 0, 4'd10, 8'h36, 1, 1)};
    vecs[13] = '{1'b1, mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 1)};

    rst1_n = 1'b0; rst3_n = 1'b0; ks1 = 1'b0; ks3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_lat1", 0, obs(1), mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 0));
    check("reset_lat3", 0, obs(3), mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 0));
    check("reset_state", 0, {17'd0, st1}, {17'd0, IDLE});
    @(posedge clk); #1;
    rst1_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;

    // ROUND_LAT=1 nominal sequence from the table, key_start held throughout
    for (int k = 0; k <= 13; k++) begin
      ks1 = vecs[k].ks;
      @(negedge clk);
      check("lat1_table", k, obs(1), vecs[k].exp);
      @(posedge clk); #1;
    end

    // key_start still held: no restart
    for (int k = 14; k <= 17; k++) begin
      ks1 = 1'b1;
      @(negedge clk);
      check("lat1_hold_no_restart", k, obs(1), mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 1));
      @(posedge clk); #1;
    end
    ks1 = 1'b0;
    @(negedge clk);
    check("lat1_release", 18, obs(1), mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 1));
    @(posedge clk); #1;
    run_model(1, 1, 1'b1, 1, 14, "lat1_rearm");

    // ROUND_LAT=3 with key_start dropped during round 3
    run_model(3, 3, 1'b0, 8, 34, "lat3_drop_r3");

    // restart, then asynchronous reset in the middle of round 5
    run_model(3, 3, 1'b1, 99, 16, "lat3_pre_reset");
    #1 rst3_n = 1'b0;
    #1 check("lat3_async_reset", 0, obs(3), mk(0, 0, 0, 0, 4'd0, 8'h01, 0, 0));
    #1 rst3_n = 1'b1;
    run_model(3, 3, 1'b0, 99, 34, "lat3_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
